// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-bit multiply/divide unit with HI/LO registers (MIPS-style).
// Iterative radix-2 datapath: shift-add multiply, restoring divide, with
// signs stripped at start and restored in a final FIX cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// 32x32 multiplier and skip the CALC phase (IDLE -> FIX).
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_step;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes and one radix-2 step of each algorithm.
    // acc holds {P_hi, P_lo} for multiply and {remainder, quotient} for divide.
    always_comb begin
        a_neg     = ~op[0] & a[31];
        b_neg     = ~op[0] & b[31];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        mul_step  = {mul_sum, acc_q[31:1]};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_rem   = div_ge ? 32'(div_shift - {1'b0, opb_q}) : div_shift[31:0];
        div_step  = {div_rem, acc_q[30:0], div_ge};
        prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;
        // A zero divisor yields an all-ones quotient regardless of signs.
        quot_fix  = (opb_q == '0) ? '1
                  : ((sa_q ^ sb_q) ? -acc_q[31:0] : acc_q[31:0]);
        rem_fix   = sa_q ? -acc_q[63:32] : acc_q[63:32];
    end

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
                    cnt_d   = '0;
                    state_d = CALC;
                    if (op[1]) begin
                        acc_d = {32'd0, abs_a};
                        opb_d = abs_b;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = {32'd0, abs_a} * {32'd0, abs_b};
                        opb_d   = abs_b;
                        state_d = FIX;
`else
                        acc_d = {32'd0, abs_b};
                        opb_d = abs_a;
`endif
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            CALC: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level behavioural model compared every cycle,
// directed literal cases, then randomized traffic.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif
    localparam int LAT_DIV = 33;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Arithmetic definition of each operation, result as {HI, LO}.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sp;
        int     sx, sy;
        logic [63:0] r;
        sx = x;
        sy = y;
        case (o)
            2'd0: begin
                sp = longint'(sx) * longint'(sy);
                r  = sp;
            end
            2'd1: r = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == 0)                                  r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == '1)      r = {32'd0, 32'h8000_0000};
                else                                         r = {32'(sx % sy), 32'(sx / sy)};
            end
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else        r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Behavioural model: an accepted start makes the unit busy for a fixed
    // number of cycles, after which the precomputed result lands in HI/LO.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_pend <= ref_result(op, a, b);
                m_left <= op[1] ? LAT_DIV : LAT_MUL;
            end else begin
                if (mthi) m_hi <= wdata;
                if (mtlo) m_lo <= wdata;
            end
        end
    end

    // Every cycle out of reset, DUT outputs must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'(m_done));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el, input int lat, input string nm);
        int k;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (k < 60 && !done) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, 64'(k), 64'(lat));
        check({nm, "_hi"}, 64'(hi), 64'(eh));
        check({nm, "_lo"}, 64'(lo), 64'(el));
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset = 1'b1;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        do_op(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT_MUL, "mult_neg2x3");
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_MUL, "multu_max");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_DIV, "div_neg7by2");
        do_op(2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, LAT_DIV, "divu_by0");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LAT_DIV, "div_ovf");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, LAT_DIV, "div_neg_by0");

        // DIVU 100/7 with a second start and MTHI arriving mid-operation.
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_k0", 64'(busy), 64'd1);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 9) begin
                start = 1'b1; mthi = 1'b1; wdata = 32'h55; op = 2'd0;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            if (k <= 32) check("ign_busy", 64'(busy), 64'd1);
        end
        check("ign_done", 64'(done), 64'd1);
        check("ign_busy_end", 64'(busy), 64'd0);
        check("ign_lo", 64'(lo), 64'd14);
        check("ign_hi", 64'(hi), 64'd2);

        // Simultaneous MTHI/MTLO in IDLE.
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_hi", 64'(hi), 64'h1234);
        check("mt_lo", 64'(lo), 64'h1234);
        check("mt_done", 64'(done), 64'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        do_op(2'd3, 32'd9, 32'd3, 32'd0, 32'd3, LAT_DIV, "divu_9by3");

        // Randomized traffic, including held start and mt writes while busy.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = rnd_operand();
            b     = rnd_operand();
            mthi  = ($urandom_range(0, 5) == 0);
            mtlo  = ($urandom_range(0, 5) == 0);
            wdata = $urandom;
        end
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled at the rising clk edge.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-006 a  input  32  operand A (GRF rs data): multiplicand or dividend; sampled with start.
REQ-007 b  input  32  operand B (GRF rt data): multiplier or divisor; sampled with start.
REQ-008 mthi  input  1  write wdata to HI (MTHI).
REQ-009 mtlo  input  1  write wdata to LO (MTLO).
REQ-010 wdata  input  32  data for mthi/mtlo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO take a new result.
REQ-013 hi  output  32  HI register, registered; for MFHI.
REQ-014 lo  output  32  LO register, registered; for MFLO.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX; busy SHALL be 1 exactly in CALC and FIX.
REQ-016 IDLE with start=1 at edge N: SHALL latch op, |a|, |b| and the sign flags, clear the 6-bit iteration counter, and go to CALC.
REQ-017 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 After 32 CALC steps, at edge N+32, the FSM SHALL go to FIX.
REQ-019 FIX SHALL apply sign correction and write HI/LO at edge N+33. In the cycle after that edge, done SHALL be 1 and the FSM SHALL be IDLE.
REQ-020 MULT/MULTU SHALL write the 64-bit product as {HI,LO}; MULT operands and result are two's complement.
REQ-021 DIV/DIVU SHALL write quotient to LO and remainder to HI. DIV SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 Divisor of 0 SHALL give LO=0xFFFFFFFF and HI=a, with the same latency as a normal divide.
REQ-023 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-024 start, mthi and mtlo SHALL be ignored while busy=1.
REQ-025 In IDLE, mthi/mtlo SHALL update HI/LO at the next edge; no done pulse.
REQ-026 start together with mthi or mtlo in IDLE: start SHALL win and the mt write SHALL be dropped.
REQ-027 mthi and mtlo together SHALL both write wdata.
REQ-028 HI/LO SHALL hold their previous values until the FIX write; reads during busy return old values.
REQ-029 done SHALL never be high for two consecutive cycles.
REQ-030 start held high continuously SHALL begin a new operation on the first edge back in IDLE, i.e. back-to-back operations.

Reset
REQ-031 reset=1 SHALL force immediately, without waiting for a clock edge: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal datapath registers=0.
REQ-032 reset during CALC or FIX SHALL abort the operation; no partial result SHALL reach hi/lo.
REQ-033 First operation after reset release SHALL accept start at the first rising edge with reset=0.

Configuration
REQ-034 Macro MULDIV_FAST_MUL_EN SHALL control the multiply path.
REQ-035 With MULDIV_FAST_MUL_EN defined: MULT/MULTU SHALL compute the product with a combinational 32x32 multiplier at the start edge and go directly IDLE->FIX. HI/LO are written at edge N+1, and done is high in the following cycle.
REQ-036 Without MULDIV_FAST_MUL_EN: multiplies SHALL use the 32-cycle iterative path of REQ-017/018.
REQ-037 Divide timing and results SHALL be identical in both builds.

Verification
REQ-038 MULT a=0xFFFFFFFE (-2), b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done in the cycle after edge N+33 (after edge N+1 with the macro).
REQ-039 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-040 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-041 DIVU 100/7 with a second start and mthi=1, wdata=0x55, asserted at edge N+10 -> both ignored; lo=14, hi=2; busy high after edges N..N+32.
REQ-042 mthi=1 and mtlo=1 together with wdata=0x1234 in IDLE -> hi=lo=0x1234, done stays 0.
REQ-043 Assert reset mid-CALC (edge N+15) after hi=lo=0x1234 -> busy=0, hi=lo=0 immediately; no done pulse; a new DIVU 9/3 then gives lo=3, hi=0.
